qsp_ex_stage: RTL and testbench

QSP_EX_STAGE -- requirements
Module: qsp_ex_stage

---
 rtl/qsp_ex_stage.sv | 189 ++++++++++++++++++
 tb/tb_qsp_ex_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/qsp_ex_stage.sv
// qspa_pkg: shared datapath width and ALU operation encoding.
package qspa_pkg;
    parameter int unsigned DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8,
        OP_SLT = 4'd9,
        OP_MUL = 4'd10
    } op_t;
endpackage

// qsp_ex_stage: execute stage with operand forwarding, single-cycle ALU and
// an iterative shift-add multiplier that stalls upstream while it runs.
module qsp_ex_stage
    import qspa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = qspa_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  op_t                   ex_alu_op,
    input  logic [3:0]            ex_rd_addr,
    input  logic [3:0]            ex_rs1_addr,
    input  logic [3:0]            ex_rs2_addr,
    input  logic                  ex_we,
    input  logic                  ex_use_imm,
    input  logic [DATA_WIDTH-1:0] ex_imm_ext,
    input  logic [DATA_WIDTH-1:0] ex_rs1_data,
    input  logic [DATA_WIDTH-1:0] ex_rs2_data,
    input  logic                  wb_we,
    input  logic [3:0]            wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ex_stall,
    output logic                  res_valid,
    output logic                  res_we,
    output logic [3:0]            res_rd_addr,
    output logic [DATA_WIDTH-1:0] res_data
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                r_state, w_next_state;
    logic [CW-1:0]         r_cnt, w_next_cnt;
    logic [DATA_WIDTH-1:0] r_mul_a, r_mul_b, r_acc;
    logic [DATA_WIDTH-1:0] w_next_mul_a, w_next_mul_b, w_next_acc;
    logic [DATA_WIDTH-1:0] w_op_a, w_rs2_fwd, w_op_b, w_alu, w_mul_sum;
    logic [CW-1:0]         w_shamt;
    logic                  w_alu_valid;
    logic                  w_stall;
    logic                  w_res_valid, w_res_we;
    logic [3:0]            w_res_rd;
    logic [DATA_WIDTH-1:0] w_res_data;

    // Operand selection: EX/WB result beats writeback; r0 never forwards.
    always_comb begin
        w_op_a    = ex_rs1_data;
        w_rs2_fwd = ex_rs2_data;
        if (ex_rs1_addr != 4'd0) begin
            if (res_we && (res_rd_addr == ex_rs1_addr))
                w_op_a = res_data;
            else if (wb_we && (wb_rd_addr == ex_rs1_addr))
                w_op_a = wb_data;
        end
        if (ex_rs2_addr != 4'd0) begin
            if (res_we && (res_rd_addr == ex_rs2_addr))
                w_rs2_fwd = res_data;
            else if (wb_we && (wb_rd_addr == ex_rs2_addr))
                w_rs2_fwd = wb_data;
        end
        w_op_b = ex_use_imm ? ex_imm_ext : w_rs2_fwd;
    end

    assign w_shamt = w_op_b[CW-1:0];

    // Single-cycle ALU; NOP, MUL and unused encodings are not ALU results.
    always_comb begin
        w_alu       = '0;
        w_alu_valid = 1'b1;
        case (ex_alu_op)
            OP_ADD:  w_alu = w_op_a + w_op_b;
            OP_SUB:  w_alu = w_op_a - w_op_b;
            OP_AND:  w_alu = w_op_a & w_op_b;
            OP_OR:   w_alu = w_op_a | w_op_b;
            OP_XOR:  w_alu = w_op_a ^ w_op_b;
            OP_SLL:  w_alu = w_op_a << w_shamt;
            OP_SRL:  w_alu = w_op_a >> w_shamt;
            OP_SRA:  w_alu = $signed(w_op_a) >>> w_shamt;
            OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            default: w_alu_valid = 1'b0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
    assign w_mul_sum = r_acc + (r_mul_b[0] ? r_mul_a : '0);

    // Next-state, stall and next result; anything not explicitly written is a bubble.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_mul_a = r_mul_a;
        w_next_mul_b = r_mul_b;
        w_next_acc   = r_acc;
        w_stall      = 1'b0;
        w_res_valid  = 1'b0;
        w_res_we     = 1'b0;
        w_res_rd     = '0;
        w_res_data   = '0;
        if (flush) begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ex_alu_op == OP_MUL) begin
                        w_stall      = 1'b1;
                        w_next_mul_a = w_op_a;
                        w_next_mul_b = w_op_b;
                        w_next_acc   = '0;
                        w_next_cnt   = '0;
                        w_next_state = S_BUSY;
                    end else if (w_alu_valid) begin
                        w_res_valid = 1'b1;
                        w_res_we    = ex_we;
                        w_res_rd    = ex_rd_addr;
                        w_res_data  = w_alu;
                    end
                end
                S_BUSY: begin
                    w_next_acc   = w_mul_sum;
                    w_next_mul_a = r_mul_a << 1;
                    w_next_mul_b = r_mul_b >> 1;
                    w_next_cnt   = r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        w_next_state = S_IDLE;
                        w_next_cnt   = '0;
                        w_res_valid  = 1'b1;
                        w_res_we     = ex_we;
                        w_res_rd     = ex_rd_addr;
                        w_res_data   = w_mul_sum;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Stall is forced low while reset is held so upstream is never frozen by a dying multiply.
    assign ex_stall = w_stall & rst_n;

    // State, multiplier datapath and EX/WB result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_acc       <= '0;
            res_valid   <= 1'b0;
            res_we      <= 1'b0;
            res_rd_addr <= '0;
            res_data    <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_mul_a     <= w_next_mul_a;
            r_mul_b     <= w_next_mul_b;
            r_acc       <= w_next_acc;
            res_valid   <= w_res_valid;
            res_we      <= w_res_we;
            res_rd_addr <= w_res_rd;
            res_data    <= w_res_data;
        end
    end

endmodule

// File: tb/tb_qsp_ex_stage.sv
// tb_qsp_ex_stage: directed vectors; expected results and stall-run lengths
// are queued at issue time and checked by an independent negedge monitor.
module tb_qsp_ex_stage;
    import qspa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    op_t         ex_alu_op;
    logic [3:0]  ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
    logic        ex_we, ex_use_imm;
    logic [31:0] ex_imm_ext, ex_rs1_data, ex_rs2_data;
    logic        wb_we;
    logic [3:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        ex_stall, res_valid, res_we;
    logic [3:0]  res_rd_addr;
    logic [31:0] res_data;

    qsp_ex_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_alu_op(ex_alu_op), .ex_rd_addr(ex_rd_addr),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_we(ex_we), .ex_use_imm(ex_use_imm), .ex_imm_ext(ex_imm_ext),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .ex_stall(ex_stall), .res_valid(res_valid), .res_we(res_we),
        .res_rd_addr(res_rd_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic        we;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned stall_q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned run   = 0;
    logic        mon_en   = 1'b0;
    logic        done     = 1'b0;
    logic        pert_mul = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: all comparisons happen here, at the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (!rst_n)
                chk("stall_in_reset", {63'd0, ex_stall}, 64'd0);
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {28'd0, res_rd_addr, res_data}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_rd_addr", {60'd0, res_rd_addr}, {60'd0, e.rd});
                    chk("res_we", {63'd0, res_we}, {63'd0, e.we});
                    chk("res_data", {32'd0, res_data}, {32'd0, e.data});
                end
            end else begin
                chk("bubble", {27'd0, res_we, res_rd_addr, res_data}, 64'd0);
            end
            if (ex_stall) begin
                run++;
            end else if (run != 0) begin
                if (stall_q.size() == 0)
                    chk("unexpected_stall_run", 64'(run), 64'd0);
                else
                    chk("stall_run", 64'(run), 64'(stall_q.pop_front()));
                run = 0;
            end
            if (done || cyc > 5000) begin
                if (cyc > 5000)
                    chk("timeout", 64'(cyc), 64'd5000);
                chk("results_pending", 64'(sb.size()), 64'd0);
                chk("stall_runs_pending", 64'(stall_q.size()), 64'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic issue(input op_t op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic we, input logic ui,
                         input logic [31:0] imm, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] exp);
        exp_t e;
        ex_alu_op = op; ex_rd_addr = rd; ex_rs1_addr = rs1; ex_rs2_addr = rs2;
        ex_we = we; ex_use_imm = ui; ex_imm_ext = imm;
        ex_rs1_data = d1; ex_rs2_data = d2;
        if (op != OP_NOP) begin
            e.rd = rd; e.we = we; e.data = exp;
            sb.push_back(e);
        end
        if (op == OP_MUL) begin
            stall_q.push_back(32);
            repeat (3) @(posedge clk);
            #1;
            if (pert_mul) begin
                wb_we = 1'b1; wb_rd_addr = rs1; wb_data = 32'h0;
            end
            repeat (30) @(posedge clk);
        end else begin
            @(posedge clk);
        end
        #1;
        if (pert_mul) wb_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        ex_alu_op = OP_MUL; ex_rd_addr = 4'd0; ex_rs1_addr = 4'd0; ex_rs2_addr = 4'd0;
        ex_we = 1'b1; ex_use_imm = 1'b0; ex_imm_ext = '0;
        ex_rs1_data = 32'd3; ex_rs2_data = 32'd3;
        wb_we = 1'b0; wb_rd_addr = 4'd0; wb_data = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1; ex_alu_op = OP_NOP;
        @(posedge clk); #1;

        issue(OP_ADD, 4'd1, 4'd4, 4'd0, 1'b1, 1'b1, 32'd7, 32'd5, 32'd0, 32'd12);
        issue(OP_ADD, 4'd2, 4'd5, 4'd6, 1'b1, 1'b0, 32'd0, 32'd3, 32'd4, 32'd7);
        issue(OP_SUB, 4'd3, 4'd2, 4'd7, 1'b1, 1'b0, 32'd0, 32'd0, 32'd1, 32'd6);
        issue(OP_ADD, 4'd0, 4'd5, 4'd6, 1'b1, 1'b0, 32'd0, 32'd3, 32'd4, 32'd7);
        issue(OP_SUB, 4'd3, 4'd0, 4'd7, 1'b1, 1'b0, 32'd0, 32'd10, 32'd1, 32'd9);
        wb_we = 1'b1; wb_rd_addr = 4'd9; wb_data = 32'd20;
        issue(OP_SUB, 4'd4, 4'd9, 4'd0, 1'b1, 1'b1, 32'd5, 32'd0, 32'd0, 32'd15);
        wb_rd_addr = 4'd4; wb_data = 32'd100;
        issue(OP_ADD, 4'd5, 4'd4, 4'd0, 1'b1, 1'b1, 32'd1, 32'd0, 32'd0, 32'd16);
        wb_rd_addr = 4'd9; wb_data = 32'd20;
        issue(OP_ADD, 4'd6, 4'd12, 4'd9, 1'b1, 1'b0, 32'd0, 32'd2, 32'd0, 32'd22);
        wb_we = 1'b0;
        issue(OP_SRA, 4'd6, 4'd10, 4'd0, 1'b1, 1'b1, 32'd31, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
        issue(OP_SLT, 4'd7, 4'd11, 4'd0, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1);
        issue(OP_SLT, 4'd7, 4'd11, 4'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        issue(OP_SUB, 4'd8, 4'd12, 4'd13, 1'b1, 1'b0, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF);
        issue(OP_AND, 4'd8, 4'd12, 4'd13, 1'b0, 1'b0, 32'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        issue(OP_OR,  4'd9, 4'd12, 4'd13, 1'b1, 1'b0, 32'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        issue(OP_XOR, 4'd9, 4'd12, 4'd13, 1'b1, 1'b0, 32'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        issue(OP_SLL, 4'd9, 4'd12, 4'd0, 1'b1, 1'b1, 32'd31, 32'd1, 32'd0, 32'h8000_0000);
        issue(OP_SRL, 4'd9, 4'd12, 4'd0, 1'b1, 1'b1, 32'h24, 32'h8000_0000, 32'd0, 32'h0800_0000);
        issue(OP_NOP, 4'd5, 4'd1, 4'd2, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Multiplies: forwarding disturbed mid-run, then back-to-back with forwarded A.
        pert_mul = 1'b1;
        issue(OP_MUL, 4'd9, 4'd14, 4'd15, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        pert_mul = 1'b0;
        issue(OP_MUL, 4'd10, 4'd12, 4'd13, 1'b1, 1'b0, 32'd0, 32'd7, 32'd6, 32'd42);
        issue(OP_MUL, 4'd11, 4'd10, 4'd13, 1'b1, 1'b0, 32'd0, 32'd0, 32'h10, 32'h2A0);
        issue(OP_MUL, 4'd12, 4'd12, 4'd11, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);

        // Flush at count 10 while the MUL op is still presented.
        ex_alu_op = OP_MUL; ex_rd_addr = 4'd13; ex_rs1_addr = 4'd12; ex_rs2_addr = 4'd13;
        ex_use_imm = 1'b0; ex_rs1_data = 32'd5; ex_rs2_data = 32'd5;
        stall_q.push_back(11);
        repeat (11) @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_alu_op = OP_NOP;
        repeat (40) @(posedge clk); #1;

        // One-cycle reset in the middle of a multiply.
        ex_alu_op = OP_MUL;
        stall_q.push_back(5);
        repeat (5) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; ex_alu_op = OP_NOP;
        @(posedge clk); #1;
        issue(OP_ADD, 4'd1, 4'd4, 4'd0, 1'b1, 1'b1, 32'd7, 32'd5, 32'd0, 32'd12);

        ex_alu_op = OP_NOP;
        repeat (40) @(posedge clk); #1;
        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL monitor_exit: got no summary expected summary");
        $fatal(1);
    end

endmodule
